// File: rtl/board_update_pkg.sv
// Shared connect-four definitions: board geometry, FSM encoding and cell indexing.
// Used by the board update logic and by the win checker.
package board_update_pkg;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;

  typedef logic [2:0] col_t;
  typedef logic [2:0] row_t;
  typedef logic [5:0] cell_t;
  typedef logic [5:0] count_t;

  localparam col_t   LAST_COL    = col_t'(COLS - 1);
  localparam row_t   FULL_HEIGHT = row_t'(ROWS);
  localparam count_t MAX_MOVES   = count_t'(CELLS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLACE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Flattened board bit index: 7*row + col.
  function automatic cell_t cell_index(input row_t row, input col_t col);
    return cell_t'(row) * cell_t'(COLS) + cell_t'(col);
  endfunction

endpackage

// File: rtl/board_update_if.sv
// Move request, board state and win-checker handshake between the host/checker
// (master) and the board update block (slave).
interface board_update_if;
  import board_update_pkg::*;

  logic             new_game;
  logic             drop_valid;
  col_t             drop_col;
  logic             drop_ready;
  col_t             location;
  row_t             height;
  logic [CELLS-1:0] player_register;
  logic [CELLS-1:0] onoff_register;
  logic             player;
  logic             check_valid;
  logic             wongame;
  logic             illegal;
  logic             game_over;
  logic             winner;
  logic             draw;

  modport master (
    output new_game, drop_valid, drop_col, wongame,
    input  drop_ready, location, height, player_register, onoff_register,
           player, check_valid, illegal, game_over, winner, draw
  );

  modport slave (
    input  new_game, drop_valid, drop_col, wongame,
    output drop_ready, location, height, player_register, onoff_register,
           player, check_valid, illegal, game_over, winner, draw
  );

endinterface

// File: rtl/board_update_column_counters.sv
// Per-column fill heights: increment on placement, synchronous clear, and a
// combinational read port with full flag for move legality.
module column_counters
  import board_update_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  col_t inc_col,
  input  col_t rd_col,
  output row_t rd_height,
  output logic rd_full
);

  row_t height_q [COLS];
  row_t height_d [COLS];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    height_d = height_q;
    if (clear) begin
      for (int c = 0; c < COLS; c++) height_d[c] = '0;
    end else if (inc && (inc_col <= LAST_COL) && (height_q[inc_col] != FULL_HEIGHT)) begin
      height_d[inc_col] = height_q[inc_col] + row_t'(1);
    end
  end

  always_comb begin
    rd_height = '0;
    if (rd_col <= LAST_COL) rd_height = height_q[rd_col];
    rd_full = (rd_height == FULL_HEIGHT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this small register array is reset explicitly; a board must start empty.
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      height_q <= height_d;
    end
  end

endmodule

// File: rtl/board_update.sv
// Connect-four board update: accepts column drops, places pieces, strobes the
// external win checker and tracks end-of-game status.
module board_update
  import board_update_pkg::*;
(
  input logic           clk,
  input logic           reset,
  board_update_if.slave bus
);

  logic [1:0]       state_q, state_d;
  col_t             location_q, location_d;
  row_t             height_q, height_d;
  logic [CELLS-1:0] player_reg_q, player_reg_d;
  logic [CELLS-1:0] onoff_reg_q, onoff_reg_d;
  logic             player_q, player_d;
  count_t           move_cnt_q, move_cnt_d;
  logic             illegal_q, illegal_d;
  logic             winner_q, winner_d;
  logic             draw_q, draw_d;

  logic  col_inc;
  row_t  col_height;
  logic  col_full;
  cell_t place_idx;

  column_counters u_cols (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.new_game),
    .inc       (col_inc),
    .inc_col   (location_q),
    .rd_col    (bus.drop_col),
    .rd_height (col_height),
    .rd_full   (col_full)
  );

  assign place_idx = cell_index(height_q, location_q);

  always_comb begin
    state_d      = state_q;
    location_d   = location_q;
    height_d     = height_q;
    player_reg_d = player_reg_q;
    onoff_reg_d  = onoff_reg_q;
    player_d     = player_q;
    move_cnt_d   = move_cnt_q;
    illegal_d    = 1'b0;
    winner_d     = winner_q;
    draw_d       = draw_q;
    col_inc      = 1'b0;

    if (bus.new_game) begin
      // A new game overrides any move in flight and lands exactly on the reset state.
      state_d      = ST_IDLE;
      location_d   = '0;
      height_d     = '0;
      player_reg_d = '0;
      onoff_reg_d  = '0;
      player_d     = 1'b0;
      move_cnt_d   = '0;
      winner_d     = 1'b0;
      draw_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.drop_valid) begin
            if ((bus.drop_col > LAST_COL) || col_full) begin
              illegal_d = 1'b1;
            end else begin
              location_d = bus.drop_col;
              height_d   = col_height;
              state_d    = ST_PLACE;
            end
          end
        end
        ST_PLACE: begin
          onoff_reg_d[place_idx]  = 1'b1;
          player_reg_d[place_idx] = player_q;
          col_inc                 = 1'b1;
          move_cnt_d              = move_cnt_q + count_t'(1);
          state_d                 = ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.wongame) begin
            state_d  = ST_DONE;
            winner_d = player_q;
            draw_d   = 1'b0;
          end else if (move_cnt_q == MAX_MOVES) begin
            state_d  = ST_DONE;
            winner_d = 1'b0;
            draw_d   = 1'b1;
          end else begin
            player_d = ~player_q;
            state_d  = ST_IDLE;
          end
        end
        default: ; // ST_DONE holds until new_game or reset
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      location_q   <= '0;
      height_q     <= '0;
      player_reg_q <= '0;
      onoff_reg_q  <= '0;
      player_q     <= 1'b0;
      move_cnt_q   <= '0;
      illegal_q    <= 1'b0;
      winner_q     <= 1'b0;
      draw_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      location_q   <= location_d;
      height_q     <= height_d;
      player_reg_q <= player_reg_d;
      onoff_reg_q  <= onoff_reg_d;
      player_q     <= player_d;
      move_cnt_q   <= move_cnt_d;
      illegal_q    <= illegal_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
    end
  end

  assign bus.drop_ready      = (state_q == ST_IDLE);
  assign bus.check_valid     = (state_q == ST_CHECK);
  assign bus.game_over       = (state_q == ST_DONE);
  assign bus.location        = location_q;
  assign bus.height          = height_q;
  assign bus.player_register = player_reg_q;
  assign bus.onoff_register  = onoff_reg_q;
  assign bus.player          = player_q;
  assign bus.illegal         = illegal_q;
  assign bus.winner          = winner_q;
  assign bus.draw            = draw_q;

endmodule

// File: tb/tb_board_update.sv
// Scoreboarded bench for board_update: a board model predicts each placement,
// the monitor compares it on every check_valid strobe.
module tb_board_update;
  import board_update_pkg::*;

  logic clk = 1'b0;
  logic reset;

  board_update_if bus ();

  board_update dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  loc;
    logic [2:0]  hgt;
    logic [41:0] on;
    logic [41:0] pl;
    logic        player;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [2:0]  model_h [8];
  logic [41:0] model_on, model_pl;
  logic        model_player, model_over, model_winner, model_draw;
  int          model_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 8; c++) model_h[c] = 3'd0;
    model_on     = '0;
    model_pl     = '0;
    model_player = 1'b0;
    model_over   = 1'b0;
    model_winner = 1'b0;
    model_draw   = 1'b0;
    model_cnt    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   64'(bus.drop_ready), 64'(1));
    check({tag, "_cvalid"},  64'(bus.check_valid), 64'(0));
    check({tag, "_illegal"}, 64'(bus.illegal), 64'(0));
    check({tag, "_over"},    64'(bus.game_over), 64'(0));
    check({tag, "_winner"},  64'(bus.winner), 64'(0));
    check({tag, "_draw"},    64'(bus.draw), 64'(0));
    check({tag, "_player"},  64'(bus.player), 64'(0));
    check({tag, "_loc"},     64'(bus.location), 64'(0));
    check({tag, "_hgt"},     64'(bus.height), 64'(0));
    check({tag, "_onoff"},   64'(bus.onoff_register), 64'(0));
    check({tag, "_preg"},    64'(bus.player_register), 64'(0));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ready"},  64'(bus.drop_ready), 64'(!model_over));
    check({tag, "_over"},   64'(bus.game_over), 64'(model_over));
    check({tag, "_winner"}, 64'(bus.winner), 64'(model_winner));
    check({tag, "_draw"},   64'(bus.draw), 64'(model_draw));
    check({tag, "_player"}, 64'(bus.player), 64'(model_player));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.drop_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.drop_ready) check("idle_timeout", 64'(bus.drop_ready), 64'(1));
  endtask

  // Drive one move; the model decides legality and predicts the outcome.
  task automatic do_move(input logic [2:0] col, input logic win);
    logic legal;
    int   idx;
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    legal          = (col <= 3'd6) && (model_h[col] < 3'd6);
    bus.drop_valid = 1'b1;
    bus.drop_col   = col;
    bus.wongame    = win;
    if (!legal) begin
      @(posedge clk); #1;
      bus.drop_valid = 1'b0;
      bus.wongame    = 1'b0;
      @(negedge clk);
      check("illegal_pulse", 64'(bus.illegal), 64'(1));
      check("illegal_onoff", 64'(bus.onoff_register), 64'(model_on));
      check("illegal_preg",  64'(bus.player_register), 64'(model_pl));
      check("illegal_player", 64'(bus.player), 64'(model_player));
      check("illegal_ready", 64'(bus.drop_ready), 64'(1));
      @(negedge clk);
      check("illegal_one_cycle", 64'(bus.illegal), 64'(0));
    end else begin
      idx           = 7 * int'(model_h[col]) + int'(col);
      model_on[idx] = 1'b1;
      model_pl[idx] = model_player;
      e.loc    = col;
      e.hgt    = model_h[col];
      e.on     = model_on;
      e.pl     = model_pl;
      e.player = model_player;
      e.acc    = cyc;
      sb_q.push_back(e);
      model_h[col] = model_h[col] + 3'd1;
      model_cnt++;
      if (win) begin
        model_over   = 1'b1;
        model_winner = model_player;
      end else if (model_cnt == 42) begin
        model_over = 1'b1;
        model_draw = 1'b1;
      end
      // drop_valid stays high through PLACE and CHECK; it must be ignored there.
      @(posedge clk); #1;
      @(negedge clk);
      check("place_no_illegal", 64'(bus.illegal), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("check_no_illegal", 64'(bus.illegal), 64'(0));
      @(posedge clk); #1;
      bus.drop_valid = 1'b0;
      bus.wongame    = 1'b0;
      if (!model_over) model_player = ~model_player;
      @(negedge clk);
      check_status("post_move");
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.check_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_check", 64'(bus.check_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_latency",  64'(cyc), 64'(e.acc + 2));
        check("sb_location", 64'(bus.location), 64'(e.loc));
        check("sb_height",   64'(bus.height), 64'(e.hgt));
        check("sb_onoff",    64'(bus.onoff_register), 64'(e.on));
        check("sb_preg",     64'(bus.player_register), 64'(e.pl));
        check("sb_player",   64'(bus.player), 64'(e.player));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.new_game   = 1'b0;
    bus.drop_valid = 1'b0;
    bus.drop_col   = 3'd0;
    bus.wongame    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst");

    // First move into column 3.
    do_move(3'd3, 1'b0);
    check("first_move_player", 64'(bus.player), 64'(1));

    // Fill column 0; the seventh drop is rejected.
    for (int i = 0; i < 7; i++) do_move(3'd0, 1'b0);

    // Out-of-range column.
    do_move(3'd7, 1'b0);

    // Player 1 wins.
    check("pre_win_player", 64'(bus.player), 64'(1));
    do_move(3'd1, 1'b1);
    check("win_winner", 64'(bus.winner), 64'(1));
    @(posedge clk); #1;
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'd2;
    repeat (3) begin
      @(negedge clk);
      check("done_no_illegal", 64'(bus.illegal), 64'(0));
      check("done_over",       64'(bus.game_over), 64'(1));
      check("done_ready",      64'(bus.drop_ready), 64'(0));
      check("done_onoff",      64'(bus.onoff_register), 64'(model_on));
    end
    @(posedge clk); #1;
    bus.drop_valid = 1'b0;
    bus.new_game   = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    model_clear();
    @(negedge clk);
    check_reset_outputs("ng_win");

    // Full board without a win ends in a draw.
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) do_move(3'(c), 1'b0);
    check("draw_flag",  64'(bus.draw), 64'(1));
    check("draw_over",  64'(bus.game_over), 64'(1));
    check("draw_full",  64'(bus.onoff_register), 64'h3FF_FFFF_FFFF);

    // Clear from DONE, then new_game must beat a simultaneous move.
    @(posedge clk); #1;
    bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    model_clear();
    @(negedge clk);
    check_reset_outputs("ng_draw");
    @(posedge clk); #1;
    bus.new_game   = 1'b1;
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'd2;
    @(posedge clk); #1;
    bus.new_game   = 1'b0;
    bus.drop_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("ng_prio");

    // Reset in the middle of PLACE leaves no trace.
    @(posedge clk); #1;
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'd4;
    @(posedge clk); #1;
    bus.drop_valid = 1'b0;
    #1;
    check("place_ready_low", 64'(bus.drop_ready), 64'(0));
    check("place_location",  64'(bus.location), 64'(4));
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_place");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    do_move(3'd4, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
